// File: rtl/fpu_cmd_master_if.sv
// Command/response channels and FPU CSR bus seen by the fpu_cmd_master.
// "master" is the command master's view; "slave" is the client/FPU side.
interface fpu_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic        busy;
  logic        ChipSelect;
  logic        Write;
  logic        Read;
  logic [1:0]  Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, ReadData,
    output cmd_ready, rsp_valid, rsp_result, rsp_flags, busy,
           ChipSelect, Write, Read, Address, WriteData
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, ReadData,
    input  cmd_ready, rsp_valid, rsp_result, rsp_flags, busy,
           ChipSelect, Write, Read, Address, WriteData
  );
endinterface

// File: rtl/fpu_cmd_master.sv
// Bus initiator: turns one {A, B, Op} command into the FPU CSR write/wait/read
// sequence and returns result and status flags on a valid/ready response channel.
module fpu_cmd_master #(
  parameter int CORE_WAIT    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic               Clk,
  input  logic               RstN,
  fpu_cmd_master_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_A    = 4'd1,
    S_WR_B    = 4'd2,
    S_WR_OP   = 4'd3,
    S_WAIT    = 4'd4,
    S_RD_RES  = 4'd5,
    S_LAT_RES = 4'd6,
    S_RD_ST   = 4'd7,
    S_LAT_ST  = 4'd8,
    S_RESP    = 4'd9
  } state_t;

  localparam int WAIT_W = (CORE_WAIT > 0) ? $clog2(CORE_WAIT + 1) : 1;
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((CORE_WAIT > 0) ? CORE_WAIT - 1 : 0);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY - 1);
  localparam bit                NO_WAIT   = (CORE_WAIT == 0);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [31:0]       b_r;
  logic [3:0]        op_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [LAT_W-1:0]  lat_cnt_r;
  logic [31:0]       result_r;
  logic [2:0]        flags_r;
  logic              cmd_ready_r;
  logic              rsp_valid_r;
  logic              busy_r;
  logic              cs_r;
  logic              wr_r;
  logic              rd_r;
  logic [1:0]        addr_r;
  logic [31:0]       wdata_r;

  logic              accept_s;
  logic              rsp_hs_s;
  logic              wait_done_s;
  logic              lat_done_s;
  logic              wr_d_s;
  logic              rd_d_s;
  logic [1:0]        addr_d_s;
  logic [31:0]       wdata_d_s;
  logic              cmd_ready_d_s;
  logic              rsp_valid_d_s;
  logic              busy_d_s;
  logic              unused_rd_s;

  assign accept_s    = bus.cmd_valid && cmd_ready_r;
  assign rsp_hs_s    = rsp_valid_r && bus.rsp_ready;
  assign wait_done_s = (wait_cnt_r == WAIT_LAST);
  assign lat_done_s  = (lat_cnt_r == LAT_LAST);
  assign unused_rd_s = ^bus.ReadData[31:3];

  // State, counters, captured read data and all registered outputs.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_r     <= S_IDLE;
      b_r         <= 32'd0;
      op_r        <= 4'd0;
      wait_cnt_r  <= '0;
      lat_cnt_r   <= '0;
      result_r    <= 32'd0;
      flags_r     <= 3'd0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      cs_r        <= 1'b0;
      wr_r        <= 1'b0;
      rd_r        <= 1'b0;
      addr_r      <= 2'd0;
      wdata_r     <= 32'd0;
    end else begin
      state_r <= state_nxt_s;

      if (accept_s) begin
        b_r  <= bus.cmd_b;
        op_r <= bus.cmd_op;
      end

      // Counters restart whenever their state is entered and saturate at the end value.
      if (state_r == S_WAIT && !wait_done_s) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
        wait_cnt_r <= '0;
      end

      if ((state_r == S_LAT_RES || state_r == S_LAT_ST) && !lat_done_s) begin
        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
      end else begin
        lat_cnt_r <= '0;
      end

      if (state_r == S_LAT_RES && lat_done_s) begin
        result_r <= bus.ReadData;
      end
      if (state_r == S_LAT_ST && lat_done_s) begin
        flags_r <= bus.ReadData[2:0];
      end

      cmd_ready_r <= cmd_ready_d_s;
      rsp_valid_r <= rsp_valid_d_s;
      busy_r      <= busy_d_s;
      cs_r        <= wr_d_s | rd_d_s;
      wr_r        <= wr_d_s;
      rd_r        <= rd_d_s;
      addr_r      <= addr_d_s;
      wdata_r     <= wdata_d_s;
    end
  end

  // Next-state sequencing of the write/wait/read access chain.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = S_WR_A;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WR_A:  state_nxt_s = S_WR_B;
      S_WR_B:  state_nxt_s = S_WR_OP;
      S_WR_OP: begin
        if (NO_WAIT) begin
          state_nxt_s = S_RD_RES;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_done_s) begin
          state_nxt_s = S_RD_RES;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_RD_RES: state_nxt_s = S_LAT_RES;
      S_LAT_RES: begin
        if (lat_done_s) begin
          state_nxt_s = S_RD_ST;
        end else begin
          state_nxt_s = S_LAT_RES;
        end
      end
      S_RD_ST: state_nxt_s = S_LAT_ST;
      S_LAT_ST: begin
        if (lat_done_s) begin
          state_nxt_s = S_RESP;
        end else begin
          state_nxt_s = S_LAT_ST;
        end
      end
      S_RESP: begin
        if (rsp_hs_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RESP;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Outputs for the state being entered, so the registered copies line up with it.
  // A is taken straight from the command port because WR_A is only entered on accept.
  always_comb begin
    wr_d_s    = 1'b0;
    rd_d_s    = 1'b0;
    addr_d_s  = 2'd0;
    wdata_d_s = 32'd0;
    case (state_nxt_s)
      S_WR_A: begin
        wr_d_s    = 1'b1;
        addr_d_s  = 2'd0;
        wdata_d_s = bus.cmd_a;
      end
      S_WR_B: begin
        wr_d_s    = 1'b1;
        addr_d_s  = 2'd1;
        wdata_d_s = b_r;
      end
      S_WR_OP: begin
        wr_d_s    = 1'b1;
        addr_d_s  = 2'd2;
        wdata_d_s = {28'd0, op_r};
      end
      S_RD_RES: begin
        rd_d_s   = 1'b1;
        addr_d_s = 2'd3;
      end
      S_RD_ST: begin
        rd_d_s   = 1'b1;
        addr_d_s = 2'd2;
      end
      default: begin
        wr_d_s    = 1'b0;
        rd_d_s    = 1'b0;
        addr_d_s  = 2'd0;
        wdata_d_s = 32'd0;
      end
    endcase
    // cmd_ready stays low for the cycle right after the response handshake.
    cmd_ready_d_s = (state_r == S_IDLE) && !accept_s;
    rsp_valid_d_s = (state_nxt_s == S_RESP);
    busy_d_s      = (state_nxt_s != S_IDLE);
  end

  assign bus.cmd_ready  = cmd_ready_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = result_r;
  assign bus.rsp_flags  = flags_r;
  assign bus.busy       = busy_r;
  assign bus.ChipSelect = cs_r;
  assign bus.Write      = wr_r;
  assign bus.Read       = rd_r;
  assign bus.Address    = addr_r;
  assign bus.WriteData  = wdata_r;

endmodule

// File: tb/tb_fpu_cmd_master.sv
// Scoreboard bench for fpu_cmd_master: default instance (CORE_WAIT=4, READ_LATENCY=1)
// and a fast-core instance (CORE_WAIT=0, READ_LATENCY=3), each behind a table-driven FPU slave.
module tb_fpu_cmd_master;

  logic Clk = 1'b0;
  logic RstN;
  always #5 Clk = ~Clk;

  fpu_cmd_master_if bus0 ();
  fpu_cmd_master_if bus1 ();

  fpu_cmd_master #(.CORE_WAIT(4), .READ_LATENCY(1)) u_dut0 (.Clk(Clk), .RstN(RstN), .bus(bus0.master));
  fpu_cmd_master #(.CORE_WAIT(0), .READ_LATENCY(3)) u_dut1 (.Clk(Clk), .RstN(RstN), .bus(bus1.master));

  localparam int NV = 5;
  localparam logic [31:0] VA   [NV] = '{32'h3FC00000, 32'h40000000, 32'h7F7FFFFF, 32'h00800000, 32'hBF800000};
  localparam logic [31:0] VB   [NV] = '{32'h40100000, 32'h40400000, 32'h7F7FFFFF, 32'h3F000000, 32'h3F800000};
  localparam logic [3:0]  VOP  [NV] = '{4'h0, 4'h2, 4'h0, 4'h2, 4'hF};
  localparam logic [31:0] VRES [NV] = '{32'h40700000, 32'h40C00000, 32'h7F800000, 32'h00400000, 32'h00000000};
  localparam logic [2:0]  VST  [NV] = '{3'b101, 3'b000, 3'b110, 3'b001, 3'b000};

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flags;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc0, acc1, wop0, wop1;
  logic pv0 = 1'b0;
  logic pv1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave answers reads only if the three written registers match a known vector.
  function automatic logic [31:0] rd_val(input logic [1:0] addr, input logic [31:0] a,
                                         input logic [31:0] b, input logic [3:0] op);
    logic [31:0] r;
    r = 32'hDEADBEEF;
    for (int i = 0; i < NV; i++) begin
      if (VA[i] == a && VB[i] == b && VOP[i] == op) begin
        if (addr == 2'd3) r = VRES[i];
        else if (addr == 2'd2) r = {29'd0, VST[i]};
      end
    end
    return r;
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  logic [31:0] s0_a, s0_b, s1_a, s1_b;
  logic [3:0]  s0_op, s1_op;
  logic [31:0] s0_pipe [3];
  logic [31:0] s1_pipe [3];

  always @(posedge Clk) begin
    if (bus0.Write) begin
      case (bus0.Address)
        2'd0: s0_a <= bus0.WriteData;
        2'd1: s0_b <= bus0.WriteData;
        2'd2: s0_op <= bus0.WriteData[3:0];
        default: ;
      endcase
    end
    s0_pipe[0] <= bus0.Read ? rd_val(bus0.Address, s0_a, s0_b, s0_op) : 32'hA5A5A5A5;
    s0_pipe[1] <= s0_pipe[0];
    s0_pipe[2] <= s0_pipe[1];
  end
  assign bus0.ReadData = s0_pipe[0];

  always @(posedge Clk) begin
    if (bus1.Write) begin
      case (bus1.Address)
        2'd0: s1_a <= bus1.WriteData;
        2'd1: s1_b <= bus1.WriteData;
        2'd2: s1_op <= bus1.WriteData[3:0];
        default: ;
      endcase
    end
    s1_pipe[0] <= bus1.Read ? rd_val(bus1.Address, s1_a, s1_b, s1_op) : 32'hA5A5A5A5;
    s1_pipe[1] <= s1_pipe[0];
    s1_pipe[2] <= s1_pipe[1];
  end
  assign bus1.ReadData = s1_pipe[2];

  task automatic bus_rules(input string tag, input logic cs, input logic w, input logic r,
                           input logic [1:0] ad, input logic [31:0] wd);
    check({tag, "_wr_rd_excl"}, 32'(w & r), 32'd0);
    check({tag, "_cs"}, 32'(cs), 32'(w | r));
    if (!(w | r)) begin
      check({tag, "_idle_addr"}, 32'(ad), 32'd0);
      check({tag, "_idle_wdata"}, wd, 32'd0);
    end else if (w && ad == 2'd2) begin
      check({tag, "_op_upper"}, 32'(wd[31:4]), 32'd0);
    end
  endtask

  // Monitors: protocol rules, latency, read timing and scoreboard compare on each response.
  always @(negedge Clk) begin
    exp_t e;
    bus_rules("bus0", bus0.ChipSelect, bus0.Write, bus0.Read, bus0.Address, bus0.WriteData);
    if (bus0.cmd_valid && bus0.cmd_ready) acc0 <= cyc;
    if (bus0.Write && bus0.Address == 2'd2) wop0 <= cyc;
    if (bus0.Read && bus0.Address == 2'd3) check("rd3_gap0", 32'(cyc - wop0), 32'd5);
    if (bus0.rsp_valid && !pv0) check("latency0", 32'(cyc - acc0 - 1), 32'd11);
    if (bus0.rsp_valid && bus0.rsp_ready) begin
      if (q0.size() == 0) begin
        check("rsp_unexpected0", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        check("rsp_result0", bus0.rsp_result, e.res);
        check("rsp_flags0", 32'(bus0.rsp_flags), 32'(e.flags));
      end
    end
    pv0 <= bus0.rsp_valid;
  end

  always @(negedge Clk) begin
    exp_t e;
    bus_rules("bus1", bus1.ChipSelect, bus1.Write, bus1.Read, bus1.Address, bus1.WriteData);
    if (bus1.cmd_valid && bus1.cmd_ready) acc1 <= cyc;
    if (bus1.Write && bus1.Address == 2'd2) wop1 <= cyc;
    if (bus1.Read && bus1.Address == 2'd3) check("rd3_gap1", 32'(cyc - wop1), 32'd1);
    if (bus1.rsp_valid && !pv1) check("latency1", 32'(cyc - acc1 - 1), 32'd11);
    if (bus1.rsp_valid && bus1.rsp_ready) begin
      if (q1.size() == 0) begin
        check("rsp_unexpected1", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check("rsp_result1", bus1.rsp_result, e.res);
        check("rsp_flags1", 32'(bus1.rsp_flags), 32'(e.flags));
      end
    end
    pv1 <= bus1.rsp_valid;
  end

  function automatic logic cmd_rdy(input int k);
    return (k == 0) ? bus0.cmd_ready : bus1.cmd_ready;
  endfunction

  function automatic logic rsp_hs(input int k);
    return (k == 0) ? (bus0.rsp_valid && bus0.rsp_ready) : (bus1.rsp_valid && bus1.rsp_ready);
  endfunction

  task automatic load(input int k, input int v);
    exp_t e;
    e.res   = VRES[v];
    e.flags = VST[v];
    if (k == 0) begin
      bus0.cmd_a = VA[v]; bus0.cmd_b = VB[v]; bus0.cmd_op = VOP[v]; bus0.cmd_valid = 1'b1;
      q0.push_back(e);
    end else begin
      bus1.cmd_a = VA[v]; bus1.cmd_b = VB[v]; bus1.cmd_op = VOP[v]; bus1.cmd_valid = 1'b1;
      q1.push_back(e);
    end
  endtask

  task automatic issue(input int k, input int v);
    int n;
    load(k, v);
    n = 0;
    do begin @(negedge Clk); n++; end while (!cmd_rdy(k) && n < 100);
    check("accept_wait", 32'(cmd_rdy(k)), 32'd1);
    @(posedge Clk); #1;
    if (k == 0) bus0.cmd_valid = 1'b0;
    else bus1.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int k);
    int n;
    n = 0;
    do begin @(negedge Clk); n++; end while (!rsp_hs(k) && n < 200);
    check("rsp_wait", 32'(rsp_hs(k)), 32'd1);
    @(posedge Clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, h;
    RstN = 1'b0;
    bus0.cmd_valid = 1'b0; bus0.cmd_a = 32'd0; bus0.cmd_b = 32'd0; bus0.cmd_op = 4'd0; bus0.rsp_ready = 1'b1;
    bus1.cmd_valid = 1'b0; bus1.cmd_a = 32'd0; bus1.cmd_b = 32'd0; bus1.cmd_op = 4'd0; bus1.rsp_ready = 1'b1;

    // Reset held with a command already waiting.
    load(0, 0);
    repeat (2) @(negedge Clk);
    check("rst_cmd_ready", 32'(bus0.cmd_ready), 32'd1);
    check("rst_cs", 32'(bus0.ChipSelect), 32'd0);
    check("rst_write", 32'(bus0.Write), 32'd0);
    check("rst_read", 32'(bus0.Read), 32'd0);
    check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    check("rst_result", bus0.rsp_result, 32'd0);
    check("rst_cmd_ready1", 32'(bus1.cmd_ready), 32'd1);
    #2 RstN = 1'b1;
    @(posedge Clk); #1;
    check("first_edge_busy", 32'(bus0.busy), 32'd1);
    check("first_edge_cmd_ready", 32'(bus0.cmd_ready), 32'd0);
    bus0.cmd_valid = 1'b0;
    wait_rsp(0);

    // Fast-core instance, several vectors.
    issue(1, 0); wait_rsp(1);
    issue(1, 2); wait_rsp(1);
    issue(1, 3); wait_rsp(1);

    issue(0, 3); wait_rsp(0);
    issue(0, 4); wait_rsp(0);

    // Backpressure with a second command held, then back-to-back accept timing.
    bus0.rsp_ready = 1'b0;
    issue(0, 1);
    n = 0;
    do begin @(negedge Clk); n++; end while (!bus0.rsp_valid && n < 100);
    check("bp_valid_seen", 32'(bus0.rsp_valid), 32'd1);
    @(posedge Clk); #1;
    load(0, 2);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check("bp_valid", 32'(bus0.rsp_valid), 32'd1);
      check("bp_result", bus0.rsp_result, VRES[1]);
      check("bp_flags", 32'(bus0.rsp_flags), 32'(VST[1]));
      check("bp_bus_idle", 32'(bus0.ChipSelect), 32'd0);
      check("bp_cmd_ready", 32'(bus0.cmd_ready), 32'd0);
    end
    @(posedge Clk); #1;
    bus0.rsp_ready = 1'b1;
    @(negedge Clk);
    h = cyc;
    @(posedge Clk); #1;
    check("idle_after_hs", 32'(bus0.busy), 32'd0);
    check("rsp_drop_after_hs", 32'(bus0.rsp_valid), 32'd0);
    n = 0;
    do begin @(negedge Clk); n++; end while (!bus0.cmd_ready && n < 50);
    check("b2b_accept_gap", 32'(cyc - h), 32'd2);
    @(posedge Clk); #1;
    bus0.cmd_valid = 1'b0;
    wait_rsp(0);

    // Reset during the WAIT phase aborts without a response.
    issue(0, 1);
    repeat (4) @(posedge Clk);
    #3;
    check("mid_busy_before", 32'(bus0.busy), 32'd1);
    RstN = 1'b0;
    #1;
    check("mid_rst_write", 32'(bus0.Write), 32'd0);
    check("mid_rst_read", 32'(bus0.Read), 32'd0);
    check("mid_rst_cs", 32'(bus0.ChipSelect), 32'd0);
    check("mid_rst_busy", 32'(bus0.busy), 32'd0);
    q0.delete();
    repeat (2) @(posedge Clk);
    #1 RstN = 1'b1;
    check("mid_rel_cmd_ready", 32'(bus0.cmd_ready), 32'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      check("mid_no_rsp", 32'(bus0.rsp_valid), 32'd0);
    end
    @(posedge Clk); #1;

    issue(0, 0); wait_rsp(0);
    check("queue0_empty", 32'(q0.size()), 32'd0);
    check("queue1_empty", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
